// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM states, requester ids and RV32 load/store funct3 codes
// for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic ID_CORE = 1'b0;
    localparam logic ID_DMA  = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3 == F3_LH || f3 == F3_LHU) && a[0]) || (f3 == F3_LW && a != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// dmem_arb_prio: core-first winner select with a starvation counter that
// forces a dma grant after STARVE_LIMIT consecutive core wins.
module dmem_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic core_req,
    input  logic dma_req,
    input  logic arb,
    output logic grant_core,
    output logic grant_dma
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          starved;

    always_comb begin
        starved    = cnt_q == CW'(STARVE_LIMIT);
        grant_dma  = arb && dma_req && (!core_req || starved);
        grant_core = arb && core_req && !grant_dma;
        cnt_d      = (!dma_req || grant_dma) ? '0 :
                     (grant_core && !starved) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data memory between core and dma, one transaction per 3 cycles.
// Define MISALIGN_CHECK_EN to suppress misaligned accesses and report them via *_err.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [2:0]            core_funct3,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_err,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [2:0]            dma_funct3,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_err,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                state_q;
    logic                  id_q, we_q, err_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  gnt_c, gnt_d, bad, acc, rsp;

    dmem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .dma_req    (dma_req),
        .arb        (state_q == IDLE && !reset),
        .grant_core (gnt_c),
        .grant_dma  (gnt_d)
    );

`ifdef MISALIGN_CHECK_EN
    assign bad = misaligned(f3_q, addr_q[1:0]);
`else
    assign bad = 1'b0;
`endif

    // Memory-side signals decode straight from state so an async reset drops the write at once.
    assign acc         = state_q == ACCESS;
    assign rsp         = state_q == RESP;
    assign mem_wr_en   = acc && we_q && !bad;
    assign mem_funct3  = acc ? f3_q : '0;
    assign mem_addr    = acc ? addr_q : '0;
    assign mem_wdata   = acc ? wdata_q : '0;
    assign core_gnt    = gnt_c;
    assign dma_gnt     = gnt_d;
    assign core_rvalid = rsp && id_q == ID_CORE;
    assign dma_rvalid  = rsp && id_q == ID_DMA;
    assign core_rdata  = core_rvalid ? rdata_q : '0;
    assign dma_rdata   = dma_rvalid ? rdata_q : '0;
    assign core_err    = core_rvalid && err_q;
    assign dma_err     = dma_rvalid && err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= ID_CORE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (gnt_c || gnt_d) begin
                    id_q    <= gnt_d ? ID_DMA : ID_CORE;
                    we_q    <= gnt_d ? dma_we : core_we;
                    f3_q    <= gnt_d ? dma_funct3 : core_funct3;
                    addr_q  <= gnt_d ? dma_addr : core_addr;
                    wdata_q <= gnt_d ? dma_wdata : core_wdata;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    rdata_q <= (we_q || bad) ? '0 : mem_rdata;
                    err_q   <= bad;
                    state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
